// File: rtl/timer_control_fsm.sv
// Control sequencer for the stopwatch/timer/clock/alarm datapath: button front end, mode FSM, strobes, bell.
// Optional bell auto-timeout is enabled by defining TIMER_CTRL_RING_TIMEOUT_EN.
module timer_control_fsm #(
    parameter int RING_TICKS = 3000,
    parameter int RING_W     = 12
) (
    input  logic       clockSignal,
    input  logic       resetN,
    input  logic       tick100,
    input  logic       modeInput,
    input  logic       set,
    input  logic       startOrStop,
    input  logic       splitOrReset,
    input  logic       countdownZero,
    input  logic       alarmMatch,
    output logic [1:0] mode,
    output logic       countdownLoad,
    output logic       countdownRun,
    output logic       stopwatchRun,
    output logic       lapCapture,
    output logic       stopwatchClear,
    output logic       clockLoad,
    output logic       alarmLoad,
    output logic       alarmArmed,
    output logic       ringSound
);

    typedef enum logic [1:0] {
        MODE_TIMER = 2'b00,
        MODE_SW    = 2'b01,
        MODE_CLOCK = 2'b10,
        MODE_ALARM = 2'b11
    } mode_t;

    if ((64'd1 << RING_W) <= 64'(RING_TICKS)) begin : g_ring_w_check
        $error("RING_W too narrow for RING_TICKS");
    end

    mode_t      state_q, state_d;
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] edges;
    logic       match_q, match_d_q;
    logic       load_q, crun_q, srun_q, lap_q, clr_q, clkld_q, aload_q, armed_q, ring_q;
    logic       load_d, crun_d, srun_d, lap_d, clr_d, clkld_d, aload_d, armed_d, ring_d;
    logic       ev_mode, ev_set, ev_ss, ev_sr, any_edge;
    logic       expire, alarm_hit, trigger;

    // Button vector order {modeInput, set, startOrStop, splitOrReset} doubles as priority order.
    assign edges    = sync2_q & ~prev_q;
    assign ev_mode  = edges[3];
    assign ev_set   = edges[2] & ~edges[3];
    assign ev_ss    = edges[1] & ~|edges[3:2];
    assign ev_sr    = edges[0] & ~|edges[3:1];
    assign any_edge = |edges;

    assign expire    = crun_q & countdownZero & tick100;
    assign alarm_hit = match_q & ~match_d_q & armed_q;
    assign trigger   = expire | alarm_hit;

`ifdef TIMER_CTRL_RING_TIMEOUT_EN
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;

    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            ring_cnt_q <= '0;
        end else begin
            ring_cnt_q <= ring_cnt_d;
        end
    end
`endif

    // State register: mode FSM plus every registered output and front-end flop.
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            state_q   <= MODE_TIMER;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            match_q   <= 1'b0;
            match_d_q <= 1'b0;
            load_q    <= 1'b0;
            crun_q    <= 1'b0;
            srun_q    <= 1'b0;
            lap_q     <= 1'b0;
            clr_q     <= 1'b0;
            clkld_q   <= 1'b0;
            aload_q   <= 1'b0;
            armed_q   <= 1'b0;
            ring_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= {modeInput, set, startOrStop, splitOrReset};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            match_q   <= alarmMatch;
            match_d_q <= match_q;
            load_q    <= load_d;
            crun_q    <= crun_d;
            srun_q    <= srun_d;
            lap_q     <= lap_d;
            clr_q     <= clr_d;
            clkld_q   <= clkld_d;
            aload_q   <= aload_d;
            armed_q   <= armed_d;
            ring_q    <= ring_d;
        end
    end

    // Next-state logic: a ringing bell swallows edges; triggers are applied last so they win.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        lap_d   = 1'b0;
        clr_d   = 1'b0;
        clkld_d = 1'b0;
        aload_d = 1'b0;
        crun_d  = crun_q;
        srun_d  = srun_q;
        armed_d = armed_q;
        ring_d  = ring_q;
`ifdef TIMER_CTRL_RING_TIMEOUT_EN
        ring_cnt_d = ring_cnt_q;
`endif

        if (ring_q) begin
            if (any_edge) begin
                ring_d = 1'b0;
            end
        end else if (ev_mode) begin
            state_d = mode_t'(state_q + 2'd1);
        end else begin
            case (state_q)
                MODE_TIMER: begin
                    if (ev_set || ev_sr) begin
                        load_d = 1'b1;
                        crun_d = 1'b0;
                    end else if (ev_ss && !(countdownZero && !crun_q)) begin
                        crun_d = ~crun_q;
                    end
                end
                MODE_SW: begin
                    if (ev_ss) begin
                        srun_d = ~srun_q;
                    end else if (ev_sr) begin
                        lap_d = srun_q;
                        clr_d = ~srun_q;
                    end
                end
                MODE_CLOCK: begin
                    clkld_d = ev_set;
                end
                MODE_ALARM: begin
                    if (ev_set) begin
                        aload_d = 1'b1;
                        armed_d = 1'b1;
                    end else if (ev_ss) begin
                        armed_d = ~armed_q;
                    end
                end
                default: state_d = MODE_TIMER;
            endcase
        end

`ifdef TIMER_CTRL_RING_TIMEOUT_EN
        if (ring_q && tick100) begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
            if (ring_cnt_q == RING_W'(RING_TICKS - 1)) begin
                ring_d = 1'b0;
            end
        end
        if (trigger) begin
            ring_cnt_d = '0;
        end
`endif

        if (expire) begin
            crun_d = 1'b0;
        end
        if (trigger) begin
            ring_d = 1'b1;
        end
    end

    always_comb begin
        mode           = state_q;
        countdownLoad  = load_q;
        countdownRun   = crun_q;
        stopwatchRun   = srun_q;
        lapCapture     = lap_q;
        stopwatchClear = clr_q;
        clockLoad      = clkld_q;
        alarmLoad      = aload_q;
        alarmArmed     = armed_q;
        ringSound      = ring_q;
    end

endmodule
